// File: rtl/multi_channel_pulse_gen.sv
// Multi-channel periodic pulse generator: one shared period counter drives
// NUM_CH phase/width-programmable outputs, in continuous or burst mode.
module multi_channel_pulse_gen #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    mode,
   input  logic [CNT_W-1:0]        period,
   input  logic [NUM_CH*CNT_W-1:0] width,
   input  logic [NUM_CH*CNT_W-1:0] phase,
   input  logic [CNT_W-1:0]        burst_len,
   output logic [NUM_CH-1:0]       pulses,
   output logic                    wrap,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [CNT_W-1:0]        bcnt, bcnt_nxt;
   logic [CNT_W-1:0]        period_s, period_nxt;
   logic [CNT_W-1:0]        burst_s, burst_nxt;
   logic [NUM_CH*CNT_W-1:0] width_s, width_nxt;
   logic [NUM_CH*CNT_W-1:0] phase_s, phase_nxt;
   logic                    mode_s, mode_nxt;
   logic                    done_nxt;
   logic                    run_nxt;
   logic                    wrap_nxt;
   logic [NUM_CH-1:0]       pulses_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bcnt     <= '0;
         period_s <= '0;
         burst_s  <= '0;
         width_s  <= '0;
         phase_s  <= '0;
         mode_s   <= 1'b0;
         pulses   <= '0;
         wrap     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bcnt     <= bcnt_nxt;
         period_s <= period_nxt;
         burst_s  <= burst_nxt;
         width_s  <= width_nxt;
         phase_s  <= phase_nxt;
         mode_s   <= mode_nxt;
         pulses   <= pulses_nxt;
         wrap     <= wrap_nxt;
         busy     <= run_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      bcnt_nxt   = bcnt;
      period_nxt = period_s;
      burst_nxt  = burst_s;
      width_nxt  = width_s;
      phase_nxt  = phase_s;
      mode_nxt   = mode_s;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_nxt  = RUN;
               cnt_nxt    = '0;
               bcnt_nxt   = '0;
               period_nxt = (period < MIN_PERIOD) ? MIN_PERIOD : period;
               burst_nxt  = (burst_len == '0) ? ONE : burst_len;
               width_nxt  = width;
               phase_nxt  = phase;
               mode_nxt   = mode;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               bcnt_nxt  = '0;
            end else if (cnt == period_s - ONE) begin
               cnt_nxt = '0;
               if (mode_s) begin
                  if (bcnt == burst_s - ONE) begin
                     state_nxt = IDLE;
                     bcnt_nxt  = '0;
                     done_nxt  = 1'b1;
                  end else begin
                     bcnt_nxt = bcnt + ONE;
                  end
               end
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from next-state values so they line up with the cnt they describe.
   assign run_nxt  = (state_nxt == RUN);
   assign wrap_nxt = run_nxt && (cnt_nxt == period_nxt - ONE);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [CNT_W-1:0] ph;
      logic [CNT_W-1:0] wd;
      logic [CNT_W:0]   off;

      assign ph  = phase_nxt[k*CNT_W +: CNT_W];
      assign wd  = width_nxt[k*CNT_W +: CNT_W];
      assign off = (cnt_nxt >= ph) ? ({1'b0, cnt_nxt} - {1'b0, ph})
                                   : ({1'b0, cnt_nxt} + {1'b0, period_nxt} - {1'b0, ph});
      assign pulses_nxt[k] = run_nxt && (ph < period_nxt) && (off < {1'b0, wd});
   end

endmodule
